// File: rtl/fifo2mem_writer_if.sv
// Handshake and bus signals between the packer FIFO, the SRAM write port and
// the egress side, as seen by fifo2mem_writer.
interface fifo2mem_writer_if #(
  parameter int unsigned CROPPED_DATA_WIDTH = 24,
  parameter int unsigned NUM_QUEUES         = 5,
  parameter int unsigned MEM_ADDR_WIDTH     = 19,
  parameter int unsigned MEM_DATA_WIDTH     = 64
);
  localparam int unsigned ENTRY_W = 8 * CROPPED_DATA_WIDTH + 10;

  logic [ENTRY_W-1:0]                   fifo_dout;
  logic                                 fifo_dout_valid;
  logic                                 output_enable;
  logic [NUM_QUEUES-1:0]                oq;
  logic [MEM_ADDR_WIDTH-1:0]            sram_addr;
  logic [MEM_DATA_WIDTH-1:0]            sram_wdata;
  logic                                 sram_we;
  logic                                 sram_ready;
  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] wr_ptr_out;
  logic                                 pkt_done;
  logic [2:0]                           pkt_done_q;

  // The writer itself
  modport master (
    input  fifo_dout, fifo_dout_valid, oq, sram_ready,
    output output_enable, sram_addr, sram_wdata, sram_we,
           wr_ptr_out, pkt_done, pkt_done_q
  );

  // FIFO / SRAM / egress environment
  modport slave (
    output fifo_dout, fifo_dout_valid, oq, sram_ready,
    input  output_enable, sram_addr, sram_wdata, sram_we,
           wr_ptr_out, pkt_done, pkt_done_q
  );
endinterface

// File: rtl/fifo2mem_writer.sv
// Pops packed FIFO entries, splits them into SRAM words and writes them into
// per-queue circular regions; publishes committed pointers at packet ends.
module fifo2mem_writer #(
  parameter int unsigned CROPPED_DATA_WIDTH = 24,
  parameter int unsigned NUM_QUEUES         = 5,
  parameter int unsigned MEM_ADDR_WIDTH     = 19,
  parameter int unsigned MEM_DATA_WIDTH     = 64,
  parameter int unsigned QUEUE_SIZE         = 104857
) (
  input  logic               memclk,
  input  logic               memreset,
  fifo2mem_writer_if.master  bus
);
  localparam int unsigned PAYLOAD_W = 8 * CROPPED_DATA_WIDTH;
  localparam int unsigned ENTRY_W   = PAYLOAD_W + 10;
  localparam int unsigned QW        = 3;

  typedef enum logic [1:0] {S_IDLE, S_WR0, S_WR1, S_WR2} state_t;

  state_t                    r_state;
  logic                      r_oe;
  logic                      r_sram_we;
  logic [MEM_ADDR_WIDTH-1:0] r_sram_addr;
  logic [MEM_DATA_WIDTH-1:0] r_sram_wdata;
  logic                      r_pkt_done;
  logic [2:0]                r_pkt_done_q;
  logic [PAYLOAD_W-1:0]      r_payload;
  logic                      r_hdr;
  logic                      r_tlast;
  logic                      r_drop;
  logic [QW-1:0]             r_q;
  logic [MEM_ADDR_WIDTH-1:0] r_wptr [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] r_cptr [NUM_QUEUES];

  logic                      w_consume;
  logic                      w_is_hdr;
  logic                      w_drop_next;
  logic [QW-1:0]             w_oq_idx;
  logic [QW-1:0]             w_q_sel;
  logic                      w_go;
  logic [MEM_ADDR_WIDTH-1:0] w_next_ptr;
  logic                      w_last;
  state_t                    w_state_adv;
  logic [MEM_DATA_WIDTH-1:0] w_next_word;
  logic                      w_unused_tstrb;

  // Region base of a queue, in address-width arithmetic
  function automatic logic [MEM_ADDR_WIDTH-1:0] f_base(input logic [QW-1:0] q);
    return MEM_ADDR_WIDTH'(32'(q) * QUEUE_SIZE);
  endfunction

  assign w_unused_tstrb = ^bus.fifo_dout[9:5];
  assign w_consume      = r_oe & bus.fifo_dout_valid;
  assign w_is_hdr       = (bus.fifo_dout[4:2] == 3'd0);
  assign w_drop_next    = w_is_hdr ? (bus.oq == '0) : r_drop;
  assign w_q_sel        = (w_is_hdr && bus.oq != '0) ? w_oq_idx : r_q;
  assign w_go           = bus.fifo_dout[0] & ~w_drop_next;
  assign w_next_ptr     = (r_wptr[r_q] == MEM_ADDR_WIDTH'(QUEUE_SIZE - 1)) ?
                          '0 : r_wptr[r_q] + MEM_ADDR_WIDTH'(1);

  // Lowest set bit of the one-hot queue select
  always_comb begin
    w_oq_idx = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (bus.oq[i]) w_oq_idx = QW'(i);
    end
  end

  // Last-word detection and the following word of the held entry
  always_comb begin
    w_last      = 1'b0;
    w_state_adv = S_WR1;
    w_next_word = r_payload[MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    case (r_state)
      S_WR0: begin
        w_state_adv = S_WR1;
        w_next_word = r_payload[MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end
      S_WR1: begin
        w_last      = r_hdr;
        w_state_adv = S_WR2;
        w_next_word = r_payload[2*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
      end
      S_WR2:   w_last = 1'b1;
      default: ;
    endcase
  end

  // Writer FSM: pop, write words in order, commit at packet end
  always_ff @(posedge memclk) begin
    if (!memreset) begin
      r_state      <= S_IDLE;
      r_oe         <= 1'b0;
      r_sram_we    <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_pkt_done   <= 1'b0;
      r_pkt_done_q <= '0;
      r_payload    <= '0;
      r_hdr        <= 1'b0;
      r_tlast      <= 1'b0;
      r_drop       <= 1'b0;
      r_q          <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        r_wptr[i] <= '0;
        r_cptr[i] <= '0;
      end
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_oe <= 1'b1;
          if (w_consume) begin
            r_payload <= bus.fifo_dout[ENTRY_W-1:10];
            r_hdr     <= w_is_hdr;
            r_tlast   <= bus.fifo_dout[1];
            r_drop    <= w_drop_next;
            r_q       <= w_q_sel;
            if (w_go) begin
              r_state      <= S_WR0;
              r_oe         <= 1'b0;
              r_sram_we    <= 1'b1;
              r_sram_addr  <= f_base(w_q_sel) + r_wptr[w_q_sel];
              r_sram_wdata <= bus.fifo_dout[10 +: MEM_DATA_WIDTH];
            end else if (bus.fifo_dout[1]) begin
              r_drop <= 1'b0;
            end
          end
        end
        default: begin
          if (bus.sram_ready) begin
            r_wptr[r_q] <= w_next_ptr;
            if (w_last) begin
              r_state   <= S_IDLE;
              r_oe      <= 1'b1;
              r_sram_we <= 1'b0;
              if (r_tlast) begin
                r_cptr[r_q]  <= w_next_ptr;
                r_pkt_done   <= 1'b1;
                r_pkt_done_q <= 3'(r_q);
              end
            end else begin
              r_state      <= w_state_adv;
              r_sram_addr  <= f_base(r_q) + w_next_ptr;
              r_sram_wdata <= w_next_word;
            end
          end
        end
      endcase
    end
  end

  assign bus.output_enable = r_oe;
  assign bus.sram_we       = r_sram_we;
  assign bus.sram_addr     = r_sram_addr;
  assign bus.sram_wdata    = r_sram_wdata;
  assign bus.pkt_done      = r_pkt_done;
  assign bus.pkt_done_q    = r_pkt_done_q;

  // Flatten committed pointers
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_cptr
    assign bus.wr_ptr_out[g*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH] = r_cptr[g];
  end
endmodule

// File: tb/tb_fifo2mem_writer.sv
// Randomized scoreboard bench for fifo2mem_writer with a queue-level model.
module tb_fifo2mem_writer;
  localparam int unsigned CDW = 24;
  localparam int unsigned NQ  = 5;
  localparam int unsigned AW  = 19;
  localparam int unsigned DW  = 64;
  localparam int unsigned QS  = 37;
  localparam int unsigned PW  = 8 * CDW;
  localparam int unsigned EW  = PW + 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [2:0]       q;
    logic [NQ*AW-1:0] ptrs;
  } done_t;

  logic memclk = 1'b0;
  logic memreset = 1'b0;
  always #5 memclk = ~memclk;

  fifo2mem_writer_if #(.CROPPED_DATA_WIDTH(CDW), .NUM_QUEUES(NQ),
                       .MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW)) bus ();

  fifo2mem_writer #(.CROPPED_DATA_WIDTH(CDW), .NUM_QUEUES(NQ), .MEM_ADDR_WIDTH(AW),
                    .MEM_DATA_WIDTH(DW), .QUEUE_SIZE(QS))
    dut (.memclk(memclk), .memreset(memreset), .bus(bus));

  int    checks = 0;
  int    failures = 0;
  int    n_acc = 0;
  bit    rand_ready = 1'b0;
  wr_t   exp_wr[$];
  done_t exp_done[$];

  // Reference model state
  int m_wptr[NQ];
  int m_cptr[NQ];
  int m_q;
  bit m_drop;

  function automatic void model_reset();
    for (int i = 0; i < NQ; i++) begin
      m_wptr[i] = 0;
      m_cptr[i] = 0;
    end
    m_q    = 0;
    m_drop = 1'b0;
    exp_wr.delete();
    exp_done.delete();
  endfunction

  // Apply the consumption of one FIFO entry to the model
  function automatic void model_consume(input logic [EW-1:0] e, input logic [NQ-1:0] oq);
    logic [PW-1:0] pl;
    logic [2:0]    pkg;
    int            nw;
    wr_t           w;
    done_t         d;
    pl  = e[EW-1:10];
    pkg = e[4:2];
    if (pkg == 3'd0) begin
      if (oq == '0) m_drop = 1'b1;
      else begin
        m_drop = 1'b0;
        for (int i = NQ - 1; i >= 0; i--) if (oq[i]) m_q = i;
      end
    end
    if (e[0] && !m_drop) begin
      nw = (pkg == 3'd0) ? 2 : 3;
      for (int n = 0; n < nw; n++) begin
        w.addr = AW'(m_q * QS + m_wptr[m_q]);
        w.data = pl[n*DW +: DW];
        exp_wr.push_back(w);
        m_wptr[m_q] = (m_wptr[m_q] + 1) % QS;
      end
      if (e[1]) begin
        m_cptr[m_q] = m_wptr[m_q];
        d.q = 3'(m_q);
        for (int i = 0; i < NQ; i++) d.ptrs[i*AW +: AW] = AW'(m_cptr[i]);
        exp_done.push_back(d);
      end
    end else if (e[1]) begin
      m_drop = 1'b0;
    end
  endfunction

  // Monitor: compare accepted writes and commit pulses against the scoreboard
  logic          stalled_prev = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;
  always @(negedge memclk) begin
    if (memreset) begin
      if (stalled_prev) begin
        checks++;
        if (!(bus.sram_we && !bus.output_enable && bus.sram_addr == prev_addr &&
              bus.sram_wdata == prev_data)) begin
          failures++;
          $display("FAIL stall_hold got we=%0b oe=%0b addr=%0d data=%h want we=1 oe=0 addr=%0d data=%h",
                   bus.sram_we, bus.output_enable, bus.sram_addr, bus.sram_wdata, prev_addr, prev_data);
        end
      end
      stalled_prev = bus.sram_we && !bus.sram_ready;
      prev_addr    = bus.sram_addr;
      prev_data    = bus.sram_wdata;
      if (bus.sram_we && bus.sram_ready) begin
        wr_t w;
        checks++;
        n_acc++;
        if (exp_wr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write got addr=%0d data=%h want none", bus.sram_addr, bus.sram_wdata);
        end else begin
          w = exp_wr.pop_front();
          if (bus.sram_addr != w.addr || bus.sram_wdata != w.data) begin
            failures++;
            $display("FAIL sram_write got addr=%0d data=%h want addr=%0d data=%h",
                     bus.sram_addr, bus.sram_wdata, w.addr, w.data);
          end
        end
      end
      if (bus.pkt_done) begin
        done_t d;
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pkt_done got q=%0d want none", bus.pkt_done_q);
        end else begin
          d = exp_done.pop_front();
          if (bus.pkt_done_q != d.q || bus.wr_ptr_out != d.ptrs) begin
            failures++;
            $display("FAIL pkt_done got q=%0d ptrs=%h want q=%0d ptrs=%h",
                     bus.pkt_done_q, bus.wr_ptr_out, d.q, d.ptrs);
          end
        end
      end
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge memclk);
    #1;
    if (rand_ready) bus.sram_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic gap(input int n);
    bus.fifo_dout_valid = 1'b0;
    bus.oq = NQ'($urandom);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [EW-1:0] mk(input logic [PW-1:0] pl, input logic [2:0] pkg,
                                      input logic tlast, input logic wren);
    return {pl, 5'($urandom), pkg, tlast, wren};
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // Present one entry until the DUT pops it
  task automatic send(input logic [EW-1:0] e, input logic [NQ-1:0] oq);
    bit consumed = 1'b0;
    bus.fifo_dout = e;
    bus.oq = oq;
    bus.fifo_dout_valid = 1'b1;
    for (int i = 0; i < 200 && !consumed; i++) begin
      @(negedge memclk);
      if (bus.output_enable && memreset) begin
        model_consume(e, oq);
        consumed = 1'b1;
      end
      step();
    end
    bus.fifo_dout_valid = 1'b0;
    if (!consumed) begin
      checks++;
      failures++;
      $display("FAIL consume_timeout got oe=%0b want 1", bus.output_enable);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_wr.size() == 0 && exp_done.size() == 0 && bus.output_enable) done = 1'b1;
      else step();
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout got pending_wr=%0d pending_done=%0d want 0 0",
               exp_wr.size(), exp_done.size());
    end
  endtask

  task automatic check_val(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  initial begin
    int acc0;
    logic [PW-1:0] pl;
    model_reset();
    bus.fifo_dout = '0;
    bus.fifo_dout_valid = 1'b0;
    bus.oq = '0;
    bus.sram_ready = 1'b1;
    memreset = 1'b0;
    repeat (2) @(posedge memclk);
    #1;
    check_val("reset_outputs",
              128'({bus.output_enable, bus.sram_we, bus.sram_addr, bus.pkt_done, bus.pkt_done_q}), 128'd0);
    check_val("reset_wdata", 128'(bus.sram_wdata), 128'd0);
    check_val("reset_wr_ptr", 128'(bus.wr_ptr_out), 128'd0);
    memreset = 1'b1;
    step();
    check_val("oe_after_release", 128'(bus.output_enable), 128'd1);

    // Header to queue 2 then a single data entry
    pl = rnd_pl();
    pl[127:0] = {64'h1111111111111111, 64'h2222222222222222};
    send(mk(pl, 3'd0, 1'b0, 1'b1), 5'b00100);
    send(mk(rnd_pl(), 3'd1, 1'b1, 1'b1), 5'b00001);
    drain();
    step();
    check_val("q2_ptr", 128'(bus.wr_ptr_out[2*AW +: AW]), 128'd5);

    // Stall during WR1
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00010);
    step();
    bus.sram_ready = 1'b0;
    repeat (4) step();
    check_val("stall_no_commit", 128'(bus.wr_ptr_out[1*AW +: AW]), 128'd0);
    bus.sram_ready = 1'b1;
    send(mk(rnd_pl(), 3'd2, 1'b1, 1'b1), 5'b00000);
    drain();

    // Queue 0 wraps: 35 words, then a 3-word entry
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00001);
    for (int i = 0; i < 11; i++) send(mk(rnd_pl(), 3'd1, 1'b0, 1'b1), 5'b00010);
    send(mk(rnd_pl(), 3'd2, 1'b1, 1'b1), 5'b00010);
    drain();
    step();
    check_val("q0_wrap_ptr", 128'(bus.wr_ptr_out[0 +: AW]), 128'd1);

    // Dropped packet, then normal packet to queue 0
    acc0 = n_acc;
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00000);
    send(mk(rnd_pl(), 3'd1, 1'b0, 1'b1), 5'b00100);
    send(mk(rnd_pl(), 3'd2, 1'b1, 1'b1), 5'b01000);
    drain();
    check_val("drop_no_write", 128'(n_acc - acc0), 128'd0);
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00001);
    send(mk(rnd_pl(), 3'd1, 1'b1, 1'b1), 5'b00000);
    drain();
    check_val("after_drop_writes", 128'(n_acc - acc0), 128'd5);

    // Entry with wren=0 inside a packet
    acc0 = n_acc;
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00010);
    send(mk(rnd_pl(), 3'd1, 1'b0, 1'b0), 5'b00000);
    send(mk(rnd_pl(), 3'd2, 1'b1, 1'b1), 5'b00000);
    drain();
    check_val("wren0_writes", 128'(n_acc - acc0), 128'd5);

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int p = 0; p < 120; p++) begin
      logic [NQ-1:0] oq;
      int nd;
      oq = ($urandom_range(0, 7) == 0) ? '0 : NQ'($urandom_range(1, (1 << NQ) - 1));
      nd = $urandom_range(0, 3);
      send(mk(rnd_pl(), 3'd0, nd == 0, $urandom_range(0, 9) != 0), oq);
      for (int k = 0; k < nd; k++) begin
        send(mk(rnd_pl(), 3'($urandom_range(1, 7)), k == nd - 1, $urandom_range(0, 9) != 0),
             NQ'($urandom));
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
    end
    drain();
    rand_ready = 1'b0;
    bus.sram_ready = 1'b1;

    // Reset while the third word of an entry is pending
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00100);
    send(mk(rnd_pl(), 3'd1, 1'b1, 1'b1), 5'b00000);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        if (exp_wr.size() == 1 && bus.sram_we) hit = 1'b1;
        else step();
      end
      check_val("reached_wr2", 128'(hit), 128'd1);
    end
    memreset = 1'b0;
    bus.sram_ready = 1'b0;
    step();
    check_val("midwrite_reset_outputs",
              128'({bus.output_enable, bus.sram_we, bus.sram_addr, bus.pkt_done}), 128'd0);
    check_val("midwrite_reset_ptrs", 128'(bus.wr_ptr_out), 128'd0);
    model_reset();
    memreset = 1'b1;
    bus.sram_ready = 1'b1;
    step();
    check_val("oe_after_midwrite_reset", 128'(bus.output_enable), 128'd1);
    send(mk(rnd_pl(), 3'd0, 1'b0, 1'b1), 5'b00001);
    send(mk(rnd_pl(), 3'd1, 1'b1, 1'b1), 5'b00000);
    drain();
    step();
    check_val("post_reset_q0_ptr", 128'(bus.wr_ptr_out[0 +: AW]), 128'd5);
    check_val("post_reset_q2_ptr", 128'(bus.wr_ptr_out[2*AW +: AW]), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo2mem_writer.md
Name: fifo2mem_writer

Overview:
- Stage directly downstream of the AXI-to-FIFO packer's async FIFO, in the memclk domain.
- Pops packed 202-bit entries ({payload, tstrb_count, pkg_state, tlast, wren}), splits each into 64-bit SRAM words, and writes them into per-output-queue circular regions of the external SRAM.
- Publishes committed per-queue write pointers at packet boundaries for the SRAM read/egress side.

Parameters:
- CROPPED_DATA_WIDTH, 24, payload bytes per FIFO entry; entry width = 8*CROPPED_DATA_WIDTH+10 = 202.
- NUM_QUEUES, 5, number of output queues.
- MEM_ADDR_WIDTH, 19, SRAM word address width.
- MEM_DATA_WIDTH, 64, SRAM word width in bits.
- QUEUE_SIZE, 104857, words per queue region; queue q base = q*QUEUE_SIZE.

Ports:
- memclk  in  1  clock; sole clock of the block.
- memreset  in  1  synchronous, active-low reset.
- fifo_dout  in  202  FIFO entry: [201:10] payload, [9:5] tstrb_count, [4:2] pkg_state, [1] tlast, [0] wren.
- fifo_dout_valid  in  1  fifo_dout holds a valid entry.
- output_enable  out  1  pop request to FIFO; entry consumed when output_enable && fifo_dout_valid.
- oq  in  NUM_QUEUES  one-hot destination queue, valid while a header entry (pkg_state==0) is presented.
- sram_addr  out  MEM_ADDR_WIDTH  SRAM write word address.
- sram_wdata  out  MEM_DATA_WIDTH  SRAM write data.
- sram_we  out  1  write request.
- sram_ready  in  1  SRAM accepts the write this cycle when sram_we && sram_ready.
- wr_ptr_out  out  NUM_QUEUES*MEM_ADDR_WIDTH  committed per-queue word offsets; queue q at [q*19 +: 19].
- pkt_done  out  1  one-cycle pulse when a packet commits.
- pkt_done_q  out  3  queue index accompanying pkt_done.

Behaviour:
- Reset (memreset==0 at memclk edge): state=IDLE; output_enable=0; sram_we=0; sram_addr=0; sram_wdata=0; pkt_done=0; pkt_done_q=0; all working and committed pointers=0; drop flag=0. Reset mid-write abandons the word without completing it.
- FSM states: IDLE, WR0, WR1, WR2.
- IDLE:
  - output_enable=1 combinationally in IDLE only.
  - On consume, latch the entry into a holding register. If pkg_state==0, also latch the queue index: lowest set bit of oq; oq==0 sets the drop flag.
  - Next state is WR0 if wren==1 and drop==0. Otherwise stay in IDLE: the entry is discarded, and if tlast==1 the drop flag clears.
- Word count per entry: 2 for header (pkg_state==0, tuser in [137:10]); 3 otherwise (all 192 payload bits). No partial-word trimming.
- Word n = payload bits [10+64n +: 64], lowest first.
- WRn:
  - sram_we=1; sram_addr = base(q) + wptr[q]; sram_wdata = word n.
  - Hold all outputs stable until sram_ready.
  - On accept, wptr[q] = (wptr[q]==QUEUE_SIZE-1) ? 0 : wptr[q]+1.
  - Then go to WR(n+1), or finish after the last word.
- Finish: if latched tlast==1, copy wptr[q] into committed pointer q and pulse pkt_done with pkt_done_q=q on the cycle after the final accept. Return to IDLE. Throughput is at most 1 entry per 3–4 cycles.
- base(q) is computed with MEM_ADDR_WIDTH-bit arithmetic; the top region must fit, so NUM_QUEUES*QUEUE_SIZE ≤ 2^MEM_ADDR_WIDTH.
- No occupancy check here; upstream admission control guarantees space. A wrap simply overwrites.
- oq changing during WRn has no effect; the queue is latched per packet.
- A header arriving with the drop flag set clears drop and re-evaluates oq.
- Committed pointers never change mid-packet.

Test Plan:
- Reset with memreset=0 for 2 cycles → all outputs 0; output_enable=1 on the first cycle after release.
- Header (pkg_state=0, oq=5'b00100, tuser=128'h1111…_2222…) then one data entry with tlast=1, sram_ready=1 → 5 writes at addresses 2*QUEUE_SIZE+0..4 with correct 64-bit slices; pkt_done pulse with pkt_done_q=2; wr_ptr_out[q2]=5.
- sram_ready held 0 for 4 cycles during WR1 → sram_addr, sram_wdata and sram_we stable throughout; no pointer advance; output_enable=0.
- Queue 0 working pointer preset to QUEUE_SIZE-2, 3-word entry → addresses QUEUE_SIZE-2, QUEUE_SIZE-1, 0; pointer ends at 1.
- Header with oq=0, followed by 2 data entries (last with tlast=1) → no sram_we, no pkt_done, all 3 entries consumed; next header with oq=5'b00001 writes normally.
- Entry with wren=0 → consumed, no write; memreset asserted during WR2 → IDLE next cycle, pointers 0, no pkt_done.
